mips_run_ctrl: RTL

Run/debug sequencer between the board-level clock/reset and Top_MIPS. It gates the CPU with a clock-enable and issues a one-cycle CPU reset on start. Three run modes are supported: continuous until halt, single-step, and run-N-cycles. It counts executed cycles and enforces a watchdog timeout, so benches and the board terminate deterministically instead of relying on mips_halt alone.

---
 rtl/mips_run_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run/debug sequencer gating Top_MIPS with enable, start reset, cycle count and watchdog
module mips_run_ctrl #(
    parameter int NBITS   = 32,
    parameter int RUNBITS = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic               basys_clk,
    input  logic               basys_reset,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic               i_step,
    input  logic [RUNBITS-1:0] i_run_cycles,
    input  logic               i_mips_halt,
    output logic               o_mips_enable,
    output logic               o_mips_reset,
    output logic [NBITS-1:0]   o_cycle_count,
    output logic               o_done,
    output logic               o_timeout,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CPURST = 3'd1,
        S_RUN    = 3'd2,
        S_STEPW  = 3'd3,
        S_STEPX  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_CONT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_RUNN = 2'b10;

    // One extra bit so count+1 never wraps before being compared to the limit.
    localparam logic [NBITS:0] TIMEOUT_W = (NBITS+1)'(TIMEOUT);

    state_t               state, state_nxt;
    logic [1:0]           mode, mode_nxt;
    logic [RUNBITS-1:0]   remaining, remaining_nxt;
    logic [NBITS-1:0]     cycle_count, cycle_count_nxt;
    logic                 timeout_q, timeout_nxt;

    logic [NBITS:0]       count_plus;
    logic [NBITS-1:0]     count_sat;
    logic                 hits_timeout;
    logic                 enable;

    always_ff @(posedge basys_clk) begin
        if (basys_reset) begin
            state       <= S_IDLE;
            mode        <= MODE_CONT;
            remaining   <= '0;
            cycle_count <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode        <= mode_nxt;
            remaining   <= remaining_nxt;
            cycle_count <= cycle_count_nxt;
            timeout_q   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        mode_nxt        = mode;
        remaining_nxt   = remaining;
        cycle_count_nxt = cycle_count;
        timeout_nxt     = timeout_q;

        count_plus   = {1'b0, cycle_count} + {{NBITS{1'b0}}, 1'b1};
        count_sat    = (cycle_count == {NBITS{1'b1}}) ? cycle_count : count_plus[NBITS-1:0];
        hits_timeout = (count_plus == TIMEOUT_W);
        enable       = ((state == S_RUN) || (state == S_STEPX)) && !i_mips_halt;

        case (state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_nxt       = S_CPURST;
                    mode_nxt        = (i_mode == 2'b11) ? MODE_CONT : i_mode;
                    remaining_nxt   = i_run_cycles;
                    cycle_count_nxt = '0;
                    timeout_nxt     = 1'b0;
                end
            end
            S_CPURST: begin
                if (mode == MODE_STEP)
                    state_nxt = S_STEPW;
                else if ((mode == MODE_RUNN) && (remaining == '0))
                    state_nxt = S_DONE;
                else
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                // A halted edge is not an executed cycle, so nothing counts.
                if (i_mips_halt) begin
                    state_nxt = S_DONE;
                end else begin
                    cycle_count_nxt = count_sat;
                    if (mode == MODE_RUNN)
                        remaining_nxt = remaining - 1'b1;
                    if ((mode == MODE_RUNN) && (remaining == {{(RUNBITS-1){1'b0}}, 1'b1})) begin
                        state_nxt = S_DONE;
                    end else if (hits_timeout) begin
                        state_nxt   = S_DONE;
                        timeout_nxt = 1'b1;
                    end
                end
            end
            S_STEPW: begin
                if (i_mips_halt)
                    state_nxt = S_DONE;
                else if (i_step)
                    state_nxt = S_STEPX;
            end
            S_STEPX: begin
                if (i_mips_halt) begin
                    state_nxt = S_DONE;
                end else begin
                    cycle_count_nxt = count_sat;
                    if (hits_timeout) begin
                        state_nxt   = S_DONE;
                        timeout_nxt = 1'b1;
                    end else begin
                        state_nxt = S_STEPW;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_mips_enable = enable;
    assign o_mips_reset  = (state == S_CPURST);
    assign o_done        = (state == S_DONE);
    assign o_cycle_count = cycle_count;
    assign o_timeout     = timeout_q;
    assign o_state       = state;

endmodule
